// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: operand forwarding,
// load-use bubbles, branch squash, timed data-memory wait handling and perf counters.
module hazard_controller #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             LoadE,
   input  logic             PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic             MemErrSticky,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_ABORT = 2'd2
   } state_e;

   localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

   state_e           state_q;
   logic [7:0]       cnt_q;
   logic             mem_err_q;
   logic             sticky_q;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic             lw_stall_s;
   logic             mem_wait_s;
   logic             stall_front_s;
   logic             flush_d_s;

   // Memory-stage producer wins over Writeback so the youngest value is forwarded.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       wr_m, input logic [4:0] rd_m,
                                          input logic       wr_w, input logic [4:0] rd_w);
      logic [1:0] sel;
      if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Hazard detection and pipeline control equations.
   always_comb begin
      lw_stall_s = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
      if (state_q == S_ABORT) begin
         mem_wait_s = 1'b0;
      end else begin
         mem_wait_s = MemReqM && !MemReadyM;
      end
      stall_front_s = mem_wait_s || (lw_stall_s && !PCSrcE);
      flush_d_s     = PCSrcE && !mem_wait_s;
      ForwardAE     = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
      ForwardBE     = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
      StallF        = stall_front_s;
      StallD        = stall_front_s;
      StallE        = mem_wait_s;
      StallM        = mem_wait_s;
      FlushW        = mem_wait_s;
      FlushD        = flush_d_s;
      FlushE        = (PCSrcE || lw_stall_s) && !mem_wait_s;
   end

   // Memory wait FSM; MemErr is high exactly while the FSM sits in ABORT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= 8'd0;
         mem_err_q <= 1'b0;
         sticky_q  <= 1'b0;
      end else begin
         mem_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (mem_wait_s) begin
                  state_q <= S_WAIT;
                  cnt_q   <= 8'd1;
               end else begin
                  state_q <= S_IDLE;
                  cnt_q   <= 8'd0;
               end
            end
            S_WAIT: begin
               if (MemReadyM) begin
                  state_q <= S_IDLE;
                  cnt_q   <= 8'd0;
               end else if (cnt_q == LAST_CNT) begin
                  state_q   <= S_ABORT;
                  cnt_q     <= 8'd0;
                  mem_err_q <= 1'b1;
                  sticky_q  <= 1'b1;
               end else begin
                  state_q <= S_WAIT;
                  cnt_q   <= cnt_q + 8'd1;
               end
            end
            S_ABORT: begin
               state_q <= S_IDLE;
               cnt_q   <= 8'd0;
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= 8'd0;
            end
         endcase
      end
   end

   // Performance counter next-state; both wrap naturally at 2^CNT_W.
   always_comb begin
      if (stall_front_s) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
      if (flush_d_s) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else begin
         flush_cnt_d = flush_cnt_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign MemErr       = mem_err_q;
   assign MemErrSticky = sticky_q;
   assign StallCount   = stall_cnt_q;
   assign FlushCount   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: directed test-plan cases plus randomized traffic
// checked against a run-length behavioural model of the memory wait/timeout rules.
module tb_hazard_controller;

   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 8;

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww, loade, pcsrc, req, rdy;
   } stim_t;

   typedef struct {
      logic [1:0]       fa, fb;
      logic [3:0]       st;
      logic [2:0]       fl;
      logic             err, sticky;
      logic [CNT_W-1:0] sc, fc;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
   logic [1:0] ForwardAE, ForwardBE;
   logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr, MemErrSticky;
   logic [CNT_W-1:0] StallCount, FlushCount;

   always #5 clk = ~clk;

   hazard_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
      .RdE(RdE), .RdM(RdM), .RdW(RdW),
      .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .LoadE(LoadE), .PCSrcE(PCSrcE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .MemErr(MemErr), .MemErrSticky(MemErrSticky),
      .StallCount(StallCount), .FlushCount(FlushCount)
   );

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   // Reference model state: length of the current stall run, abort-cycle flag, sticky, counters.
   int               m_run    = 0;
   bit               m_abort  = 1'b0;
   bit               m_sticky = 1'b0;
   logic [CNT_W-1:0] m_sc     = '0;
   logic [CNT_W-1:0] m_fc     = '0;

   function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input stim_t s);
      if (s.rwm && s.rdm != 5'd0 && s.rdm == rs) return 2'b10;
      if (s.rww && s.rdw != 5'd0 && s.rdw == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp, input int c);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
   endtask

   // Drive one cycle, push the model's expected response, then advance the model past the edge.
   task automatic step(input stim_t s, input logic r);
      exp_t e;
      bit mw, lw, front;
      @(negedge clk);
      rst = r;
      Rs1D = s.rs1d; Rs2D = s.rs2d; Rs1E = s.rs1e; Rs2E = s.rs2e;
      RdE = s.rde; RdM = s.rdm; RdW = s.rdw;
      RegWriteM = s.rwm; RegWriteW = s.rww; LoadE = s.loade; PCSrcE = s.pcsrc;
      MemReqM = s.req; MemReadyM = s.rdy;
      if (r) begin
         m_run = 0; m_abort = 1'b0; m_sticky = 1'b0; m_sc = '0; m_fc = '0;
      end
      mw    = s.req && !s.rdy && !m_abort;
      lw    = s.loade && s.rde != 5'd0 && (s.rde == s.rs1d || s.rde == s.rs2d);
      front = mw || (lw && !s.pcsrc);
      e.fa = ref_fwd(s.rs1e, s);
      e.fb = ref_fwd(s.rs2e, s);
      e.st = {front, front, mw, mw};
      e.fl = {s.pcsrc && !mw, (s.pcsrc || lw) && !mw, mw};
      e.err = m_abort;
      e.sticky = m_sticky;
      e.sc = m_sc;
      e.fc = m_fc;
      e.cyc = cyc;
      q.push_back(e);
      cyc++;
      if (!r) begin
         m_sc = m_sc + CNT_W'(front);
         m_fc = m_fc + CNT_W'(e.fl[2]);
         if (m_abort) begin
            m_abort = 1'b0;
            m_run = 0;
         end else if (mw) begin
            m_run++;
            if (m_run == TIMEOUT) begin
               m_abort = 1'b1;
               m_sticky = 1'b1;
               m_run = 0;
            end
         end else begin
            m_run = 0;
         end
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s.rs1d = 5'd0; s.rs2d = 5'd0; s.rs1e = 5'd0; s.rs2e = 5'd0;
      s.rde = 5'd0; s.rdm = 5'd0; s.rdw = 5'd0;
      s.rwm = 1'b0; s.rww = 1'b0; s.loade = 1'b0; s.pcsrc = 1'b0; s.req = 1'b0; s.rdy = 1'b0;
      return s;
   endfunction

   // Monitor: pops one expectation per cycle and compares it with the sampled outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("ForwardAE", 32'(ForwardAE), 32'(e.fa), e.cyc);
            check("ForwardBE", 32'(ForwardBE), 32'(e.fb), e.cyc);
            check("StallFDEM", 32'({StallF, StallD, StallE, StallM}), 32'(e.st), e.cyc);
            check("FlushDEW", 32'({FlushD, FlushE, FlushW}), 32'(e.fl), e.cyc);
            check("MemErr", 32'(MemErr), 32'(e.err), e.cyc);
            check("MemErrSticky", 32'(MemErrSticky), 32'(e.sticky), e.cyc);
            check("StallCount", 32'(StallCount), 32'(e.sc), e.cyc);
            check("FlushCount", 32'(FlushCount), 32'(e.fc), e.cyc);
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1'b1;
      s = idle();
      step(s, 1'b1);
      step(s, 1'b1);
      step(s, 1'b0);
      // Forwarding priority and x0 exclusion.
      s = idle(); s.rdm = 5'd5; s.rwm = 1'b1; s.rs1e = 5'd5; s.rdw = 5'd5; s.rww = 1'b1; s.rs2e = 5'd5;
      step(s, 1'b0);
      s.rdm = 5'd0; s.rs1e = 5'd0;
      step(s, 1'b0);
      // Load-use, then load-use with a taken branch.
      s = idle(); s.loade = 1'b1; s.rde = 5'd7; s.rs2d = 5'd7;
      step(s, 1'b0);
      s.pcsrc = 1'b1;
      step(s, 1'b0);
      // Three wait cycles, then ready.
      s = idle(); s.req = 1'b1;
      repeat (3) step(s, 1'b0);
      s.rdy = 1'b1;
      step(s, 1'b0);
      // Timeout: four stalled cycles plus the abort cycle.
      s = idle(); s.req = 1'b1;
      repeat (TIMEOUT + 1) step(s, 1'b0);
      s = idle();
      repeat (2) step(s, 1'b0);
      // Memory wait dominating a branch and a load-use hazard.
      s = idle(); s.req = 1'b1; s.pcsrc = 1'b1; s.loade = 1'b1; s.rde = 5'd3; s.rs1d = 5'd3;
      repeat (2) step(s, 1'b0);
      s.rdy = 1'b1;
      step(s, 1'b0);
      // Reset asserted mid-wait, request dropped while still in reset.
      s = idle(); s.req = 1'b1;
      repeat (2) step(s, 1'b0);
      step(s, 1'b1);
      s = idle();
      step(s, 1'b1);
      step(s, 1'b0);
      // Randomized traffic; an outstanding request is held until it completes or aborts.
      for (int i = 0; i < 1500; i++) begin
         s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
         s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
         s.rde = 5'($urandom_range(0, 3)); s.rdm = 5'($urandom_range(0, 3));
         s.rdw = 5'($urandom_range(0, 3));
         s.rwm = 1'($urandom_range(0, 1)); s.rww = 1'($urandom_range(0, 1));
         s.loade = ($urandom_range(0, 2) == 0);
         s.pcsrc = ($urandom_range(0, 3) == 0);
         s.req = (m_run > 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
         s.rdy = ($urandom_range(0, 2) == 0);
         step(s, ($urandom_range(0, 299) == 0));
      end
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain got=%0d expected=0", q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
